// File: rtl/ram_mp.sv
// Multi-read, single-write synchronous RAM with a built-in clear sequencer.
// Reads take 1 cycle per port. A clear sweep takes DEPTH cycles after reset or after CLR_REQ.
// No backpressure: while BUSY is high, user writes are dropped and read outputs register 0.
//
// Ports:
//   CLK, RST         clock (rising edge); asynchronous active-low reset
//   PORT_RD_ADDRESS  NRD packed read addresses, port i = [i*AWIDTH +: AWIDTH]
//   PORT_RD_OUT      NRD packed registered read data, port i = [i*DWIDTH +: DWIDTH]
//   PORT_W_ADDRESS   write address
//   PORT_W_DATA      write data
//   PORT_W_WE        write enable, active-low
//   CLR_REQ          starts a clear sweep when sampled in IDLE
//   BUSY             high while the clear sequencer owns the array
module ram_mp #(
  parameter int unsigned       DWIDTH = 1,
  parameter int unsigned       AWIDTH = 2,
  parameter int unsigned       NRD    = 2,
  parameter logic [DWIDTH-1:0] INIT   = '0,
  parameter bit                BYPASS = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NRD*AWIDTH-1:0]    PORT_RD_ADDRESS,
  output logic [NRD*DWIDTH-1:0]    PORT_RD_OUT,
  input  logic [AWIDTH-1:0]        PORT_W_ADDRESS,
  input  logic [DWIDTH-1:0]        PORT_W_DATA,
  input  logic                     PORT_W_WE,
  input  logic                     CLR_REQ,
  output logic                     BUSY
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AWIDTH-1:0]       cnt_q, cnt_d;
  logic [NRD*DWIDTH-1:0]   rd_out_q, rd_out_d;
  logic [DWIDTH-1:0]       mem_q [DEPTH];

  logic                    user_we;
  logic                    mem_we;
  logic [AWIDTH-1:0]       mem_waddr;
  logic [DWIDTH-1:0]       mem_wdata;

  // State register, sweep counter and read-output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Next-state logic. The last sweep word and the return to IDLE share one edge,
  // so a sweep occupies exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (&cnt_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: array write port mux, read data and BUSY.
  always_comb begin
    BUSY      = (state_q == ST_CLEAR);
    // A user write on the same edge as CLR_REQ still lands: state_q is still IDLE.
    user_we   = (state_q == ST_IDLE) && !PORT_W_WE;
    mem_we    = 1'b0;
    mem_waddr = PORT_W_ADDRESS;
    mem_wdata = PORT_W_DATA;
    rd_out_d  = '0;

    if (state_q == ST_CLEAR) begin
      // The sweep owns the only write port. While RST is held low this keeps
      // rewriting word 0 with INIT, which the restarted sweep does anyway.
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT;
    end else begin
      mem_we = user_we;
      for (int i = 0; i < NRD; i++) begin
        if (BYPASS && user_we &&
            (PORT_RD_ADDRESS[i*AWIDTH +: AWIDTH] == PORT_W_ADDRESS)) begin
          rd_out_d[i*DWIDTH +: DWIDTH] = PORT_W_DATA;
        end else begin
          rd_out_d[i*DWIDTH +: DWIDTH] = mem_q[PORT_RD_ADDRESS[i*AWIDTH +: AWIDTH]];
        end
      end
    end

    PORT_RD_OUT = rd_out_q;
  end

  // Storage has no reset; contents come only from user writes or the sweep.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ram_mp.sv
// Bench for ram_mp: two instances (write-first and read-old) share stimulus.
// Stimulus pushes expected post-edge values into a scoreboard; a monitor pops
// and compares them shortly after each rising edge.
module tb_ram_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_addr;
  logic [15:0] rd_a, rd_b;
  logic [1:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_we;
  logic        clr_req;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_mp #(.DWIDTH(8), .AWIDTH(2), .NRD(2), .INIT(8'hA5), .BYPASS(1'b1)) u_dut_byp (
    .CLK(clk), .RST(rst_n), .PORT_RD_ADDRESS(rd_addr), .PORT_RD_OUT(rd_a),
    .PORT_W_ADDRESS(w_addr), .PORT_W_DATA(w_data), .PORT_W_WE(w_we),
    .CLR_REQ(clr_req), .BUSY(busy_a)
  );

  ram_mp #(.DWIDTH(8), .AWIDTH(2), .NRD(2), .INIT(8'hA5), .BYPASS(1'b0)) u_dut_old (
    .CLK(clk), .RST(rst_n), .PORT_RD_ADDRESS(rd_addr), .PORT_RD_OUT(rd_b),
    .PORT_W_ADDRESS(w_addr), .PORT_W_DATA(w_data), .PORT_W_WE(w_we),
    .CLR_REQ(clr_req), .BUSY(busy_b)
  );

  typedef struct {
    int         cyc;
    logic       busy;
    logic [7:0] a0, a1, b0, b1;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  function automatic void chk1(string name, logic act, logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endfunction

  function automatic void chk8(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic void check_all(string name, exp_t e);
    chk1({name, "/busy_byp"}, busy_a, e.busy);
    chk1({name, "/busy_old"}, busy_b, e.busy);
    chk8({name, "/byp_rd0"}, rd_a[7:0],  e.a0);
    chk8({name, "/byp_rd1"}, rd_a[15:8], e.a1);
    chk8({name, "/old_rd0"}, rd_b[7:0],  e.b0);
    chk8({name, "/old_rd1"}, rd_b[15:8], e.b1);
  endfunction

  // Asynchronous-reset check taken between edges.
  function automatic void check_rst_now(string name);
    exp_t e;
    e.cyc = cyc; e.busy = 1'b1;
    e.a0 = 8'h00; e.a1 = 8'h00; e.b0 = 8'h00; e.b1 = 8'h00;
    check_all(name, e);
  endfunction

  // Monitor: compares every expectation due at the current cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n = sb_name.pop_front();
        if (e.cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL %s: expectation for cycle %0d missed, now %0d", n, e.cyc, cyc);
        end else begin
          check_all(n, e);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, input logic clr,
                       input logic [1:0] r0, input logic [1:0] r1);
    @(negedge clk);
    rst_n   = r;
    w_we    = we;
    w_addr  = wa;
    w_data  = wd;
    clr_req = clr;
    rd_addr = {r1, r0};
  endtask

  // Expected state just after the next rising edge.
  task automatic exp_push(input string name, input logic busy,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1);
    exp_t e;
    e.cyc = cyc + 1; e.busy = busy;
    e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic rd(input string name, input logic [1:0] r0, input logic [1:0] r1,
                    input logic [7:0] a0, input logic [7:0] a1,
                    input logic [7:0] b0, input logic [7:0] b1);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, r0, r1);
    exp_push(name, 1'b0, a0, a1, b0, b1);
  endtask

  task automatic wr(input string name, input logic [1:0] wa, input logic [7:0] wd,
                    input logic [1:0] r0, input logic [1:0] r1,
                    input logic [7:0] a0, input logic [7:0] a1,
                    input logic [7:0] b0, input logic [7:0] b1, input logic clr);
    drive(1'b1, 1'b0, wa, wd, clr, r0, r1);
    exp_push(name, clr, a0, a1, b0, b1);
  endtask

  // Four sweep edges: BUSY stays high after the first three, drops on the fourth.
  task automatic sweep_check(input string name);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
      exp_push($sformatf("%s_%0d", name, k), (k < 3), 8'h00, 8'h00, 8'h00, 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0; w_we = 1'b1; w_addr = '0; w_data = '0; clr_req = 1'b0; rd_addr = '0;
    #1;
    check_rst_now("t1_rst");
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
    exp_push("t1_rst_edge", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

    // 1: reset release sweep, then every word reads INIT
    sweep_check("t1_sweep");
    rd("t1_rd01", 2'd0, 2'd1, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    rd("t1_rd23", 2'd2, 2'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    // 2: write then read one cycle later
    wr("t2_wr", 2'd2, 8'h3C, 2'd0, 2'd0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    rd("t2_rd", 2'd2, 2'd1, 8'h3C, 8'hA5, 8'h3C, 8'hA5);

    // 3: read-during-write on port 0; port 1 on another address unaffected
    wr("t3_rdw", 2'd1, 8'h77, 2'd1, 2'd2, 8'h77, 8'h3C, 8'hA5, 8'h3C, 1'b0);
    rd("t3_same", 2'd1, 2'd1, 8'h77, 8'h77, 8'h77, 8'h77);

    // 4: fill with read-during-write on both ports, then clear with a blocked write
    wr("t4_w0", 2'd0, 8'h11, 2'd0, 2'd0, 8'h11, 8'h11, 8'hA5, 8'hA5, 1'b0);
    wr("t4_w1", 2'd1, 8'h22, 2'd1, 2'd1, 8'h22, 8'h22, 8'h77, 8'h77, 1'b0);
    wr("t4_w2", 2'd2, 8'h33, 2'd2, 2'd2, 8'h33, 8'h33, 8'h3C, 8'h3C, 1'b0);
    wr("t4_w3", 2'd3, 8'h44, 2'd3, 2'd3, 8'h44, 8'h44, 8'hA5, 8'hA5, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3);
    exp_push("t4_req", 1'b1, 8'h11, 8'h44, 8'h11, 8'h44);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    exp_push("t4_c1", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd0);
    exp_push("t4_c2_wr_req", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    exp_push("t4_c3", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    exp_push("t4_c4", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    rd("t4_rd01", 2'd0, 2'd1, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    rd("t4_rd23", 2'd2, 2'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    // 5: reset dropped at CNT=2 of a sweep
    wr("t5_w2", 2'd2, 8'hC2, 2'd0, 2'd0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    wr("t5_w3", 2'd3, 8'hC3, 2'd0, 2'd0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3);
    exp_push("t5_req", 1'b1, 8'hC2, 8'hC3, 8'hC2, 8'hC3);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3);
    exp_push("t5_c0", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3);
    exp_push("t5_c1", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3);
    #1;
    check_rst_now("t5_rst");
    exp_push("t5_rst_edge", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    sweep_check("t5_sweep");
    rd("t5_rd01", 2'd0, 2'd1, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    rd("t5_rd23", 2'd2, 2'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    // 6: clear request and write on the same edge
    drive(1'b1, 1'b0, 2'd3, 8'h5A, 1'b1, 2'd3, 2'd2);
    exp_push("t6_req_wr", 1'b1, 8'h5A, 8'hA5, 8'hA5, 8'hA5);
    sweep_check("t6_sweep");
    rd("t6_rd", 2'd3, 2'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    // 7: async reset clears nonzero outputs between edges
    wr("t7_wr", 2'd1, 8'h99, 2'd0, 2'd0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    rd("t7_rd", 2'd1, 2'd1, 8'h99, 8'h99, 8'h99, 8'h99);
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 2'd1, 2'd1);
    #1;
    check_rst_now("t7_rst");
    exp_push("t7_rst_edge", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    sweep_check("t7_sweep");
    rd("t7_rd_after", 2'd1, 2'd0, 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
